// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary back end: counts ones of a qualified bitstream over a
// fixed window (after an optional warm-up) and hands the count over valid/ready.
module sc_stream_counter #(
  parameter int LEN   = 256,
  parameter int SKIP  = 8,
  parameter int RES_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic             busy,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COUNT, S_HOLD} state_t;

  localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [RES_W-1:0]  LEN_LAST  = RES_W'(LEN - 1);

  state_t              state_q;
  logic [RES_W-1:0]    ones_q, ones_d;
  logic [RES_W-1:0]    samp_q, samp_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [RES_W-1:0]    result_q;
  logic                valid_q;

  always_comb begin
    ones_d = ones_q + RES_W'(bit_in);
    samp_d = samp_q + RES_W'(1);
    skip_d = skip_q + SKIP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ones_q   <= '0;
      samp_q   <= '0;
      skip_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (abort) begin
      // Cancel wins over everything; the last delivered result is kept.
      state_q <= S_IDLE;
      ones_q  <= '0;
      samp_q  <= '0;
      skip_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ones_q  <= '0;
            samp_q  <= '0;
            skip_q  <= '0;
            state_q <= (SKIP == 0) ? S_COUNT : S_WARMUP;
          end
        end
        S_WARMUP: begin
          if (skip_q == SKIP_LAST) begin
            state_q <= S_COUNT;
          end else begin
            skip_q <= skip_d;
          end
        end
        S_COUNT: begin
          if (bit_en) begin
            ones_q <= ones_d;
            samp_q <= samp_d;
            // The final sample's own bit is folded into the loaded result.
            if (samp_q == LEN_LAST) begin
              result_q <= ones_d;
              valid_q  <= 1'b1;
              state_q  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule
